// File: rtl/key_scanner.sv
// key_scanner: synchronises, debounces and serialises NKEYS key lines into 8-bit press/release events through a small FIFO.
// Build macro KEY_TOGGLE_EN: key_state becomes a per-key latch that flips on each debounced press.
module key_scanner #(
   parameter int NKEYS      = 16,
   parameter int DEBOUNCE   = 500000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NKEYS-1:0] key_raw,
   output logic [NKEYS-1:0] key_state,
   output logic             evt_valid,
   output logic [7:0]       evt_code,
   input  logic             evt_ready,
   output logic             overflow,
   input  logic             clr_ovf
);
   localparam int CW = $clog2(DEBOUNCE);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);

   logic [NKEYS-1:0] sync1_q, sync2_q, samp_q, lvl_q, pend_q, pend_d, upd, first;
   logic [CW-1:0]    cnt_q;
   logic             tick;
   logic [6:0]       idx;
   logic [7:0]       push_code, head_d;
   logic             push, pop, push_ok;
   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q, rptr_d;
   logic [NW-1:0]    fill_q, fill_d;
   logic             valid_q, ovf_q;
   logic [7:0]       code_q;

   assign tick = cnt_q == CW'(DEBOUNCE - 1);

   // two-flop synchroniser per key line
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= key_raw;
         sync2_q <= sync1_q;
      end
   end

   // sample-tick counter, wraps every DEBOUNCE cycles
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else cnt_q <= tick ? '0 : cnt_q + 1'b1;
   end

   // a key changes level only when two consecutive ticks agree and differ from the current level
   always_comb begin
      upd    = tick ? (sync2_q ~^ samp_q) & (sync2_q ^ lvl_q) : '0;
      pend_d = (pend_q & ~first) | upd;
   end

   // debounced level, tick sample and per-key pending-event mask
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         samp_q <= '0;
         lvl_q  <= '0;
         pend_q <= '0;
      end else begin
         if (tick) samp_q <= sync2_q;
         lvl_q  <= lvl_q ^ upd;
         pend_q <= pend_d;
      end
   end

   // pick the lowest pending key and form its event code
   always_comb begin
      idx = '0;
      for (int i = NKEYS - 1; i >= 0; i--) if (pend_q[i]) idx = 7'(i);
      first     = pend_q & (-pend_q);
      push      = |pend_q;
      push_code = {|(first & lvl_q), idx};
   end

   // FIFO control; the head bypass covers a push landing in the slot the read pointer moves to
   always_comb begin
      pop     = valid_q & evt_ready;
      push_ok = push & ((fill_q != NW'(FIFO_DEPTH)) | pop);
      rptr_d  = rptr_q + PW'(pop);
      fill_d  = fill_q + NW'(push_ok) - NW'(pop);
      head_d  = (push_ok && wptr_q == rptr_d) ? push_code : mem_q[rptr_d];
   end

   // FIFO storage, pointers, registered head outputs and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         fill_q  <= '0;
         valid_q <= 1'b0;
         code_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (push_ok) mem_q[wptr_q] <= push_code;
         wptr_q  <= wptr_q + PW'(push_ok);
         rptr_q  <= rptr_d;
         fill_q  <= fill_d;
         valid_q <= fill_d != '0;
         code_q  <= head_d;
         ovf_q   <= (push & ~push_ok) | (ovf_q & ~clr_ovf);
      end
   end

   assign evt_valid = valid_q;
   assign evt_code  = code_q;
   assign overflow  = ovf_q;

`ifdef KEY_TOGGLE_EN
   logic [NKEYS-1:0] tog_q;

   // flip the presented state on each debounced press, ignore releases
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) tog_q <= '0;
      else tog_q <= tog_q ^ (upd & sync2_q);
   end

   assign key_state = tog_q;
`else
   assign key_state = lvl_q;
`endif

endmodule

// File: tb/tb_key_scanner.sv
// tb_key_scanner: directed checks of debounce timing, event ordering, FIFO full/overflow and reset.
module tb_key_scanner;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key_raw = '0;
   logic       evt_ready = 1'b1;
   logic       clr_ovf = 1'b0;
   logic [3:0] key_state;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       overflow;
   int         checks = 0;
   int         errors = 0;
   int         e = 0;
   int         nv;

   key_scanner #(.NKEYS(4), .DEBOUNCE(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .key_raw(key_raw), .key_state(key_state),
      .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
      .overflow(overflow), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance to the negedge following rising edge n since reset release
   task automatic go(input int n);
      while (e < n) begin
         @(negedge clk);
         e++;
      end
   endtask

   task automatic quiet(input int n, output int cnt);
      cnt = 0;
      while (e < n) begin
         @(negedge clk);
         e++;
         cnt += (evt_valid === 1'b1) ? 1 : 0;
      end
   endtask

   initial begin
      key_raw = 4'b0100;
      repeat (3) @(negedge clk);
      chk("rst_state", key_state, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b1;
      go(15); chk("first_tick_early", key_state, 4'b0000);
      go(16); chk("press_state", key_state, 4'b0100);
      chk("press_not_yet_valid", evt_valid, 0);
      go(17); chk("press_valid", evt_valid, 1);
      chk("press_code", evt_code, 8'h82);
      go(18); chk("press_popped", evt_valid, 0);
      key_raw = 4'b0000;
      go(31); chk("release_hold", key_state, 4'b0100);
      go(32); chk("release_state", key_state, 4'b0000);
      go(33); chk("release_valid", evt_valid, 1);
      chk("release_code", evt_code, 8'h02);
      quiet(50, nv); chk("one_event_per_edge", nv, 0);
      go(56); key_raw = 4'b0010;
      go(61); key_raw = 4'b0000;
      quiet(80, nv); chk("glitch_no_event", nv, 0);
      chk("glitch_state", key_state, 4'b0000);
      key_raw = 4'b1011;
      go(96); chk("multi_state", key_state, 4'b1011);
      go(97); chk("multi_v0", evt_valid, 1); chk("multi_c0", evt_code, 8'h80);
      go(98); chk("multi_v1", evt_valid, 1); chk("multi_c1", evt_code, 8'h81);
      go(99); chk("multi_v2", evt_valid, 1); chk("multi_c2", evt_code, 8'h83);
      go(100); chk("multi_done", evt_valid, 0);
      key_raw = 4'b0000;
      go(113); chk("multi_rel_code", evt_code, 8'h00);
      go(120); evt_ready = 1'b0; key_raw = 4'b1111;
      go(140); chk("full_valid", evt_valid, 1); chk("full_head", evt_code, 8'h80);
      key_raw = 4'b0000;
      go(152); chk("ovf_before", overflow, 0); chk("ovf_rel_state", key_state, 4'b0000);
      go(153); chk("ovf_set", overflow, 1);
      go(156); chk("ovf_head_kept", evt_code, 8'h80);
      go(160); evt_ready = 1'b1; chk("drain0", evt_code, 8'h80);
      go(161); chk("drain1", evt_code, 8'h81);
      go(162); chk("drain2", evt_code, 8'h82);
      go(163); chk("drain3", evt_code, 8'h83);
      go(164); chk("drain_empty", evt_valid, 0); chk("ovf_sticky", overflow, 1);
      go(165); clr_ovf = 1'b1;
      go(166); chk("ovf_cleared", overflow, 0); clr_ovf = 1'b0;
      go(170); evt_ready = 1'b0; key_raw = 4'b1111;
      go(184); chk("fp_press_state", key_state, 4'b1111);
      go(188); key_raw = 4'b0000;
      go(200); chk("fp_head", evt_code, 8'h80); chk("fp_valid", evt_valid, 1);
      evt_ready = 1'b1;
      go(201); chk("fp_c1", evt_code, 8'h81);
      go(202); chk("fp_c2", evt_code, 8'h82);
      go(203); chk("fp_c3", evt_code, 8'h83);
      go(204); chk("fp_c4", evt_code, 8'h00);
      go(205); chk("fp_c5", evt_code, 8'h01);
      go(206); chk("fp_c6", evt_code, 8'h02);
      go(207); chk("fp_c7", evt_code, 8'h03);
      go(208); chk("fp_empty", evt_valid, 0); chk("fp_no_ovf", overflow, 0);
      go(210); evt_ready = 1'b0; key_raw = 4'b1111;
      go(228); key_raw = 4'b0000;
      go(240); chk("prio_before", overflow, 0); clr_ovf = 1'b1;
      go(241); chk("prio_set_wins", overflow, 1); clr_ovf = 1'b0; key_raw = 4'b1111;
      go(256); chk("mid_state", key_state, 4'b1111); chk("mid_valid", evt_valid, 1);
      chk("mid_ovf", overflow, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_state", key_state, 0);
      chk("mid_rst_valid", evt_valid, 0);
      chk("mid_rst_code", evt_code, 0);
      chk("mid_rst_ovf", overflow, 0);
      evt_ready = 1'b1;
      repeat (2) @(negedge clk);
      e = 0;
      rst = 1'b1;
      go(15); chk("re_tick_early", key_state, 4'b0000);
      go(16); chk("re_state", key_state, 4'b1111);
      go(17); chk("re_c0", evt_code, 8'h80);
      go(18); chk("re_c1", evt_code, 8'h81);
      go(19); chk("re_c2", evt_code, 8'h82);
      go(20); chk("re_c3", evt_code, 8'h83);
      go(21); chk("re_empty", evt_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
